// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcode values and FSM state encoding.
package alu_arbiter_pkg;

   localparam logic [3:0] OpSll  = 4'd1;
   localparam logic [3:0] OpSrl  = 4'd2;
   localparam logic [3:0] OpSra  = 4'd3;
   localparam logic [3:0] OpAdd  = 4'd4;
   localparam logic [3:0] OpSub  = 4'd5;
   localparam logic [3:0] OpLui  = 4'd6;
   localparam logic [3:0] OpSlt  = 4'd7;
   localparam logic [3:0] OpSltu = 4'd8;
   localparam logic [3:0] OpXor  = 4'd9;
   localparam logic [3:0] OpOr   = 4'd10;
   localparam logic [3:0] OpAnd  = 4'd11;
   localparam logic [3:0] OpMul  = 4'd12;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// port that did not win last time.
module alu_arbiter_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Sequences one shared combinational ALU between two requesters, one
// operation in flight, with registered operands and results.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned OPWIDTH   = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [OPWIDTH-1:0]   req0_op,
   input  logic [DATAWIDTH-1:0] req0_rs1,
   input  logic [DATAWIDTH-1:0] req0_rs2,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [OPWIDTH-1:0]   req1_op,
   input  logic [DATAWIDTH-1:0] req1_rs1,
   input  logic [DATAWIDTH-1:0] req1_rs2,
   output logic                 resp0_valid,
   input  logic                 resp0_ready,
   output logic                 resp1_valid,
   input  logic                 resp1_ready,
   output logic [DATAWIDTH-1:0] resp_rd,
   output logic                 resp_overflow,
   output logic [OPWIDTH-1:0]   alu_op,
   output logic [DATAWIDTH-1:0] alu_rs1,
   output logic [DATAWIDTH-1:0] alu_rs2,
   input  logic [DATAWIDTH-1:0] alu_rd,
   input  logic                 alu_overflow,
   output logic                 busy
);

   state_e               state_q, state_d;
   logic                 last_grant_q;
   logic                 owner_q;
   logic [OPWIDTH-1:0]   op_q;
   logic [DATAWIDTH-1:0] rs1_q, rs2_q;
   logic [DATAWIDTH-1:0] rd_q;
   logic                 ovf_q;

   logic [1:0] grant;
   logic       accept;
   logic       capture;
   logic       release_owner;

   alu_arbiter_rr_arb2 u_rr_arb2 (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   always_comb begin
      state_d       = state_q;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      resp0_valid   = 1'b0;
      resp1_valid   = 1'b0;
      accept        = 1'b0;
      capture       = 1'b0;
      release_owner = 1'b0;
      unique case (state_q)
         StIdle: begin
            req0_ready = grant[0];
            req1_ready = grant[1];
            if (grant != 2'b00) begin
               accept  = 1'b1;
               state_d = StExec;
            end
         end
         StExec: begin
            capture = 1'b1;
            state_d = StResp;
         end
         StResp: begin
            resp0_valid = ~owner_q;
            resp1_valid = owner_q;
            // Only the owner's ready retires the result.
            if (owner_q ? resp1_ready : resp0_ready) begin
               release_owner = 1'b1;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         ovf_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q <= grant[1];
            op_q    <= grant[1] ? req1_op  : req0_op;
            rs1_q   <= grant[1] ? req1_rs1 : req0_rs1;
            rs2_q   <= grant[1] ? req1_rs2 : req0_rs2;
         end
         if (capture) begin
            rd_q  <= alu_rd;
            ovf_q <= alu_overflow;
         end
         if (release_owner) begin
            last_grant_q <= owner_q;
         end
      end
   end

   assign alu_op        = op_q;
   assign alu_rs1       = rs1_q;
   assign alu_rs2       = rs2_q;
   assign resp_rd       = rd_q;
   assign resp_overflow = ovf_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single integer ALU between two requesters: port 0 is the main execute stage, port 1 is the auxiliary/multicycle unit.
- Each requester issues {op, rs1, rs2} over a valid/ready handshake and gets {rd, overflow} back over a second valid/ready handshake.
- Grants are round-robin, operands and results are registered, and one operation is in flight at a time.
- The ALU itself stays combinational; this block sequences it and drives its operand/op inputs.

Parameters:
- DATAWIDTH, 32, operand/result width; must match the ALU instance.
- OPWIDTH, 4, ALU opcode width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  OPWIDTH  ALU opcode, passed through unmodified.
- req0_rs1, req0_rs2, req1_rs1, req1_rs2  in  DATAWIDTH  operands.
- resp0_valid / resp1_valid  out  1  result available for that requester.
- resp0_ready / resp1_ready  in  1  requester takes result.
- resp_rd  out  DATAWIDTH  shared result register; qualified only by respN_valid.
- resp_overflow  out  1  shared ALU bit-32 capture.
- alu_op  out  OPWIDTH  to ALU op.
- alu_rs1, alu_rs2  out  DATAWIDTH  to ALU operands.
- alu_rd  in  DATAWIDTH  from ALU.
- alu_overflow  in  1  from ALU.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock, synchronous active-high reset on RST; RST high at a rising CLK edge forces reset state.
- Values held in reset state:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - Operand, op and result registers = 0.
  - All req*_ready, resp*_valid, resp_overflow and busy = 0.
  - alu_op, alu_rs1, alu_rs2 = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the port != last_grant.
  - reqN_ready is asserted combinationally in IDLE, only for the winner, and only while its valid is high.
  - On the handshake edge, latch op/rs1/rs2 and owner, then go to EXEC.
  - With no valid, stay in IDLE; both readies stay low.
- EXEC (one cycle):
  - The ALU sees the registered operands via alu_*, which are driven from the operand regs at all times.
  - At the end of the cycle, capture alu_rd into resp_rd and alu_overflow into resp_overflow, then go to RESP.
- RESP:
  - resp<owner>_valid = 1; the other respN_valid = 0.
  - resp_rd and resp_overflow are held stable.
  - On resp<owner>_ready, set last_grant = owner and go to IDLE.
  - A ready from the non-owner is ignored.
- Latency: request accepted at edge T, result captured at T+1, respN_valid high from T+2. Peak throughput is one operation per 3 cycles.
- No request is accepted outside IDLE. A requester may change its payload only after ready, or while its valid is low.
- Opcodes are not checked; undefined codes reach the ALU unchanged (the ALU treats them as add).
- RST mid-EXEC or mid-RESP: the operation is dropped and no response is issued; the requester must re-issue.
- A valid that drops before its handshake loses the grant with no state change.

Decomposition:
- Shared package holds:
  - ALU opcode localparams: SLL=1, SRL=2, SRA=3, ADD=4, SUB=5, LUI=6, SLT=7, SLTU=8, XOR=9, OR=10, AND=11, MUL=12.
  - FSM state encoding: IDLE, EXEC, RESP.
- One sub-module, rr_arb2: a combinational 2-way round-robin pick from (valid[1:0], last_grant) producing grant[1:0].
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req0 ADD(4'b0100), rs1=5, rs2=7, accepted at T → resp0_valid at T+2, resp_rd=12, overflow=0; resp1_valid never asserts.
- Overflow capture: req1 ADD 32'hFFFF_FFFF + 1 → resp_rd=0, resp_overflow=1; then SUB 3-5 → resp_rd=32'hFFFF_FFFE, overflow=1.
- Fairness: both valids held high continuously from reset with distinct ops → grant order 0,1,0,1; each response arrives 3 cycles apart with resp*_ready tied high.
- Backpressure: resp0_ready low for 5 cycles → resp0_valid stays high, resp_rd unchanged, req1_ready stays 0 throughout; req1 is granted the cycle after resp0_ready rises.
- Reset mid-operation: assert RST in EXEC → next cycle all outputs are 0 and state is IDLE; no respN_valid for the dropped operation.
- Pass-through: op=4'b1111, rs1=2, rs2=3 → alu_op=4'b1111 observed, resp_rd=5.
